// File: rtl/pool_layer.sv
// pool_layer: 2x2 stride-2 max-pool with optional ReLU, fed by mid_bram.
// Reads COLS*PASSES column beats of four rows. Rows (0,1) and (2,3) are
// pooled over column pairs, giving two pooled values per column pair.
module pool_layer #(
    parameter int unsigned DW     = 21,
    parameter int unsigned COLS   = 24,
    parameter int unsigned PASSES = 6,
    parameter int unsigned RELU   = 1
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          start_pool,
    input  logic          de_in,
    input  logic [DW-1:0] in0_q,
    input  logic [DW-1:0] in1_q,
    input  logic [DW-1:0] in2_q,
    input  logic [DW-1:0] in3_q,
    output logic          in_rden,
    output logic          de_out,
    output logic [DW-1:0] out0,
    output logic [DW-1:0] out1,
    output logic          busy,
    output logic          fin_pool
);

    localparam int unsigned TOTAL = COLS * PASSES;
    localparam int unsigned CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, RD, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] in_cnt;
    logic          parity;
    logic          drained;
    logic [DW-1:0] h0, h1;
    logic [DW-1:0] mx01, mx23;
    logic          rd_last, in_full, accept, final_strobe, frame_start;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] x);
        return ((RELU != 0) && x[DW-1]) ? '0 : x;
    endfunction

    assign rd_last      = (rd_cnt == CW'(TOTAL - 1));
    assign in_full      = (in_cnt == CW'(TOTAL));
    assign accept       = de_in && ((state == RD) || (state == DRAIN)) && !in_full;
    assign final_strobe = de_out && in_full;
    assign frame_start  = (state == IDLE) && start_pool;
    assign mx01         = smax(in0_q, in1_q);
    assign mx23         = smax(in2_q, in3_q);

    // State register.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx = state;
        in_rden  = 1'b0;
        busy     = 1'b0;
        fin_pool = 1'b0;
        case (state)
            IDLE: begin
                if (start_pool) state_nx = RD;
            end
            RD: begin
                in_rden = 1'b1;
                busy    = 1'b1;
                if (rd_last) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // drained covers a final strobe that already fired while still in RD
                if (final_strobe || drained) state_nx = DONE;
            end
            DONE: begin
                fin_pool = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read counter, accepted-beat counter, beat parity and drain flag.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rd_cnt  <= '0;
            in_cnt  <= '0;
            parity  <= 1'b0;
            drained <= 1'b0;
        end else if (frame_start) begin
            rd_cnt  <= '0;
            in_cnt  <= '0;
            parity  <= 1'b0;
            drained <= 1'b0;
        end else begin
            if (state == RD) rd_cnt <= rd_cnt + CW'(1);
            if (accept) begin
                in_cnt <= in_cnt + CW'(1);
                parity <= ~parity;
            end
            if (final_strobe) drained <= 1'b1;
        end
    end

    // Pooling datapath: even beats load the hold registers, odd beats emit.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            h0     <= '0;
            h1     <= '0;
            out0   <= '0;
            out1   <= '0;
            de_out <= 1'b0;
        end else begin
            de_out <= accept && parity;
            if (accept && !parity) begin
                h0 <= mx01;
                h1 <= mx23;
            end
            if (accept && parity) begin
                out0 <= relu_f(smax(h0, mx01));
                out1 <= relu_f(smax(h1, mx23));
            end
        end
    end

endmodule

// File: tb/tb_pool_layer.sv
// tb_pool_layer: directed bench for pool_layer, one ReLU and one pass-through instance.
module tb_pool_layer;

    localparam int DW    = 21;
    localparam int TOTAL = 144;

    logic          clk;
    logic          RESET;
    logic          start_pool;
    logic          de_in;
    logic [DW-1:0] in0_q, in1_q, in2_q, in3_q;
    logic          in_rden_a, de_out_a, busy_a, fin_pool_a;
    logic [DW-1:0] out0_a, out1_a;
    logic          in_rden_b, de_out_b, busy_b, fin_pool_b;
    logic [DW-1:0] out0_b, out1_b;

    int checks = 0;
    int errors = 0;

    pool_layer #(.DW(DW), .COLS(24), .PASSES(6), .RELU(1)) u_a (
        .clk(clk), .RESET(RESET), .start_pool(start_pool), .de_in(de_in),
        .in0_q(in0_q), .in1_q(in1_q), .in2_q(in2_q), .in3_q(in3_q),
        .in_rden(in_rden_a), .de_out(de_out_a), .out0(out0_a), .out1(out1_a),
        .busy(busy_a), .fin_pool(fin_pool_a)
    );

    pool_layer #(.DW(DW), .COLS(24), .PASSES(6), .RELU(0)) u_b (
        .clk(clk), .RESET(RESET), .start_pool(start_pool), .de_in(de_in),
        .in0_q(in0_q), .in1_q(in1_q), .in2_q(in2_q), .in3_q(in3_q),
        .in_rden(in_rden_b), .de_out(de_out_b), .out0(out0_b), .out1(out1_b),
        .busy(busy_b), .fin_pool(fin_pool_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] v(input int x);
        logic [31:0] t;
        t = x;
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int a, input int b, input int c, input int d);
        de_in = 1'b1;
        in0_q = v(a); in1_q = v(b); in2_q = v(c); in3_q = v(d);
    endtask

    // Two beats back to back; strobe expected exactly one cycle after the second.
    task automatic pair(input string tag,
                        input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3,
                        input int e0, input int e1_relu, input int e1_raw);
        drive(a0, a1, a2, a3);
        tick();
        chk({tag, "_no_early_strobe"}, de_out_a, 0);
        drive(b0, b1, b2, b3);
        tick();
        de_in = 1'b0;
        chk({tag, "_de_out"}, de_out_a, 1);
        chk({tag, "_out0"}, out0_a, v(e0));
        chk({tag, "_out1_relu"}, out1_a, v(e1_relu));
        chk({tag, "_out1_raw"}, out1_b, v(e1_raw));
        tick();
        chk({tag, "_strobe_one_cycle"}, de_out_a, 0);
        chk({tag, "_out0_hold"}, out0_a, v(e0));
    endtask

    // One full frame; beats follow reads by two cycles, optionally with random gaps.
    task automatic run_frame(input string tag, input bit gaps);
        int cyc, strobes, rden_cnt, fins, busy_low, last_strobe, fin_cyc;
        int iss, iss_d1, iss_d2, beats, gap, extra, k, col;
        cyc = 0; strobes = 0; rden_cnt = 0; fins = 0; busy_low = 0;
        last_strobe = -100; fin_cyc = -100;
        iss = 0; iss_d1 = 0; iss_d2 = 0; beats = 0; gap = 0; extra = 0;
        start_pool = 1'b1;
        tick();
        start_pool = 1'b0;
        chk({tag, "_busy_after_start"}, busy_a, 1);
        while (cyc < 3000 && !(fins > 0 && cyc > fin_cyc + 3)) begin
            if (in_rden_a) rden_cnt++;
            if (de_out_a) begin
                k = strobes % 12;
                chk({tag, "_de_out_b"}, de_out_b, 1);
                chk({tag, "_out0"}, out0_a, v(2 * k + 1));
                chk({tag, "_out1_relu"}, out1_a, v(0));
                chk({tag, "_out1_raw"}, out1_b, v(-2 * k));
                strobes++;
                last_strobe = cyc;
            end
            if (fin_pool_a) begin
                fins++;
                fin_cyc = cyc;
                chk({tag, "_busy_low_at_fin"}, busy_a, 0);
            end else if (fins == 0 && !busy_a) begin
                busy_low++;
            end
            // start_pool while reading and while in DONE must both be ignored
            start_pool = (cyc == 20) || fin_pool_a;
            iss_d2 = iss_d1;
            iss_d1 = iss;
            if (in_rden_a) iss++;
            if (beats < TOTAL && beats < iss_d2 && gap == 0) begin
                col = beats % 24;
                drive(col, col - 1, -col, -col - 1);
                beats++;
                gap = gaps ? int'($urandom_range(0, 5)) : 0;
            end else if (beats == TOTAL && extra < 2) begin
                drive(1000, 1000, 1000, 1000);
                extra++;
            end else begin
                de_in = 1'b0;
                if (gap > 0) gap--;
            end
            tick();
            cyc++;
        end
        de_in = 1'b0;
        start_pool = 1'b0;
        chk({tag, "_strobes"}, strobes, 72);
        chk({tag, "_rden_cycles"}, rden_cnt, TOTAL);
        chk({tag, "_fin_count"}, fins, 1);
        chk({tag, "_fin_after_last"}, fin_cyc - last_strobe, 1);
        chk({tag, "_busy_held"}, busy_low, 0);
        tick();
        chk({tag, "_idle_busy"}, busy_a, 0);
        chk({tag, "_idle_rden"}, in_rden_a, 0);
        chk({tag, "_idle_fin"}, fin_pool_a, 0);
    endtask

    initial begin
        int fins, rdens;
        RESET = 1'b1; start_pool = 1'b0; de_in = 1'b0;
        in0_q = '0; in1_q = '0; in2_q = '0; in3_q = '0;
        tick();
        tick();
        chk("rst_rden", in_rden_a, 0);
        chk("rst_de_out", de_out_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_fin", fin_pool_a, 0);
        chk("rst_out0", out0_a, 0);
        chk("rst_out1", out1_a, 0);
        RESET = 1'b0;
        tick();

        // basic pooling
        start_pool = 1'b1;
        tick();
        start_pool = 1'b0;
        chk("basic_busy", busy_a, 1);
        chk("basic_rden", in_rden_a, 1);
        pair("basic", 1, 5, -3, -2, 4, 2, -7, -1, 5, 0, -1);

        // edge values within the same frame
        pair("extreme", -1048576, 1048575, -5, -9, -1048576, -1048576, -3, -4,
             1048575, 0, -3);
        pair("equal", 7, 7, -1048576, -1048576, 7, 7, -1048576, -1048576,
             7, 0, -1048576);
        pair("negrow", -1, -2, 1048575, 1048575, -3, -1048576, 1048575, 1048575,
             0, 1048575, 1048575);
        chk("negrow_out0_raw", out0_b, v(-1));

        // asynchronous reset mid-read
        chk("pre_reset_rden", in_rden_a, 1);
        RESET = 1'b1;
        #1;
        chk("midrst_rden", in_rden_a, 0);
        chk("midrst_de_out", de_out_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_fin", fin_pool_a, 0);
        chk("midrst_out0", out0_a, 0);
        chk("midrst_out1", out1_a, 0);
        chk("midrst_out1_raw", out1_b, 0);
        tick();
        RESET = 1'b0;
        fins = 0;
        rdens = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fin_pool_a) fins++;
            if (in_rden_a) rdens++;
        end
        chk("abort_no_fin", fins, 0);
        chk("abort_no_rden", rdens, 0);

        // stray de_in while idle
        for (int i = 0; i < 5; i++) begin
            drive(500 + i, 3, 3, 3);
            tick();
        end
        de_in = 1'b0;
        chk("stray_no_strobe", de_out_a, 0);
        chk("stray_out0", out0_a, 0);
        chk("stray_busy", busy_a, 0);
        tick();

        run_frame("frame1", 1'b0);
        run_frame("frame2", 1'b0);
        run_frame("gaps", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
